// File: rtl/mux_sel_ctrl_pkg.sv
// Shared types and default constants for the design-select sequencing controller.
package mux_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_SETTLE,
        ST_QUIESCE,
        ST_SWITCH,
        ST_HOLD_RST,
        ST_RUN
    } mux_ctrl_state_t;

    localparam int DEF_ADDR_W         = 5;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_STABLE_CYCLES  = 16;
    localparam int DEF_QUIESCE_CYCLES = 2;
    localparam int DEF_RST_CYCLES     = 8;
    localparam int SW_CNT_W           = 8;

endpackage

// File: rtl/mux_sel_ctrl_sync_stable.sv
// Multi-flop synchronizer for a pad bus plus a saturating counter that reports
// when the synchronized value has held steady for STABLE_CYCLES cycles.
module sync_stable
    import mux_ctrl_pkg::*;
#(
    parameter int W             = DEF_ADDR_W,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o,
    output logic         stable_o
);

    localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int FILL_W = $clog2(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    logic [FILL_W-1:0]             fill_q;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          filled;
    logic                          changed;

    // The counter stays cleared until the chain has flushed out its reset contents,
    // and clears on the same edge that a new value lands on the output.
    assign filled  = (fill_q == FILL_W'(SYNC_STAGES));
    assign changed = (sync_q[SYNC_STAGES-2] != sync_q[SYNC_STAGES-1]);

    always_comb begin
        cnt_d = cnt_q;
        if (!filled || changed) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(STABLE_CYCLES)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            if (!filled) begin
                fill_q <= fill_q + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

    assign q_o      = sync_q[SYNC_STAGES-1];
    assign stable_o = (cnt_q == CNT_W'(STABLE_CYCLES));

endmodule

// File: rtl/mux_sel_ctrl.sv
// Safe switchover sequencer for the shared design mux: gates outputs, moves the
// select, and holds the newly selected design in reset before releasing it.
module mux_sel_ctrl
    import mux_ctrl_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int QUIESCE_CYCLES = DEF_QUIESCE_CYCLES,
    parameter int RST_CYCLES     = DEF_RST_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   addr_in,
    input  logic                user_rst_n,
    output logic [ADDR_W-1:0]   sel_addr,
    output logic                design_rst_n,
    output logic                out_en,
    output logic                busy,
    output logic [SW_CNT_W-1:0] switch_cnt
);

    localparam int PH_MAX = (QUIESCE_CYCLES > RST_CYCLES) ? QUIESCE_CYCLES : RST_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    mux_ctrl_state_t     state_q;
    logic [ADDR_W-1:0]   addr_s;
    logic                stable;
    logic [SYNC_STAGES-1:0] urst_sync_q;
    logic                urst_s;
    logic [ADDR_W-1:0]   target_q;
    logic [ADDR_W-1:0]   sel_q;
    logic [PH_W-1:0]     phase_q;
    logic                out_en_q;
    logic                busy_q;
    logic                from_settle_q;
    logic [SW_CNT_W-1:0] sw_cnt_q;

    sync_stable #(
        .W             (ADDR_W),
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_addr_sync (
        .clk      (clk),
        .rst      (rst),
        .d_i      (addr_in),
        .q_o      (addr_s),
        .stable_o (stable)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            urst_sync_q <= '0;
        end else begin
            urst_sync_q <= {urst_sync_q[SYNC_STAGES-2:0], user_rst_n};
        end
    end
    assign urst_s = urst_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_SETTLE;
            target_q      <= '0;
            sel_q         <= '0;
            phase_q       <= '0;
            out_en_q      <= 1'b0;
            busy_q        <= 1'b1;
            from_settle_q <= 1'b1;
            sw_cnt_q      <= '0;
        end else begin
            case (state_q)
                // Outputs are already gated after reset, so quiescing is skipped.
                ST_SETTLE: begin
                    if (stable) begin
                        target_q      <= addr_s;
                        from_settle_q <= 1'b1;
                        state_q       <= ST_SWITCH;
                    end
                end
                ST_RUN: begin
                    if (stable && (addr_s != sel_q)) begin
                        target_q      <= addr_s;
                        from_settle_q <= 1'b0;
                        phase_q       <= '0;
                        out_en_q      <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= ST_QUIESCE;
                    end
                end
                ST_QUIESCE: begin
                    if (phase_q == PH_W'(QUIESCE_CYCLES - 1)) begin
                        phase_q <= '0;
                        state_q <= ST_SWITCH;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                ST_SWITCH: begin
                    sel_q   <= target_q;
                    phase_q <= '0;
                    state_q <= ST_HOLD_RST;
                end
                ST_HOLD_RST: begin
                    if (phase_q == PH_W'(RST_CYCLES - 1)) begin
                        out_en_q <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= ST_RUN;
                        if (!from_settle_q) begin
                            sw_cnt_q <= sw_cnt_q + 1'b1;
                        end
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_SETTLE;
                end
            endcase
        end
    end

    assign sel_addr     = sel_q;
    assign out_en       = out_en_q;
    assign design_rst_n = out_en_q & urst_s;
    assign busy         = busy_q;
    assign switch_cnt   = sw_cnt_q;

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Self-checking bench for mux_sel_ctrl: directed scenarios plus random pad traffic,
// compared cycle by cycle against a timeline-based reference model.
module tb_mux_sel_ctrl;

    localparam int AW = 5;
    localparam int SS = 2;
    localparam int SC = 16;
    localparam int QC = 2;
    localparam int RC = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr_in;
    logic          user_rst_n;
    logic [AW-1:0] sel_addr;
    logic          design_rst_n;
    logic          out_en;
    logic          busy;
    logic [7:0]    switch_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_sel_ctrl #(
        .ADDR_W         (AW),
        .SYNC_STAGES    (SS),
        .STABLE_CYCLES  (SC),
        .QUIESCE_CYCLES (QC),
        .RST_CYCLES     (RC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .addr_in      (addr_in),
        .user_rst_n   (user_rst_n),
        .sel_addr     (sel_addr),
        .design_rst_n (design_rst_n),
        .out_en       (out_en),
        .busy         (busy),
        .switch_cnt   (switch_cnt)
    );

    // Reference model: pad sample history since reset plus a switchover timeline.
    // mode 0 = settling after reset, 1 = in a switchover sequence, 2 = running.
    int            n;
    logic [AW-1:0] samp  [64];
    logic          usamp [64];
    int            mode;
    int            k;
    logic [AW-1:0] m_sel;
    logic [AW-1:0] m_tgt;
    logic [7:0]    m_cnt;
    bit            m_from_settle;

    task automatic model_reset();
        n = 0; mode = 0; k = 0; m_sel = '0; m_tgt = '0; m_cnt = '0; m_from_settle = 1'b1;
        for (int i = 0; i < 64; i++) begin
            samp[i]  = '0;
            usamp[i] = 1'b0;
        end
    endtask

    function automatic logic [AW-1:0] addr_s_at(int m);
        return (m >= SS) ? samp[(m - SS + 1) % 64] : '0;
    endfunction

    // Stable once the synced value has been identical for SC+1 consecutive edges,
    // counting only after the synchronizer has been flushed.
    function automatic bit stable_at(int m);
        if (m < SS + SC) return 1'b0;
        for (int j = 1; j <= SC; j++) begin
            if (samp[(m - SS + 1 - j) % 64] !== samp[(m - SS + 1) % 64]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [15:0] exp_vec();
        logic oe;
        logic drn;
        oe  = (mode == 2);
        drn = oe && (n >= SS) && usamp[(n - SS + 1) % 64];
        return {m_sel, drn, oe, ~oe, m_cnt};
    endfunction

    task automatic step();
        bit            stp;
        logic [AW-1:0] asp;
        @(posedge clk);
        stp = stable_at(n);
        asp = addr_s_at(n);
        n = n + 1;
        samp[n % 64]  = addr_in;
        usamp[n % 64] = user_rst_n;
        case (mode)
            0: if (stp) begin m_tgt = asp; k = QC; mode = 1; m_from_settle = 1'b1; end
            2: if (stp && asp != m_sel) begin m_tgt = asp; k = 0; mode = 1; m_from_settle = 1'b0; end
            default: begin
                k = k + 1;
                if (k == QC + 1) m_sel = m_tgt;
                if (k == QC + 1 + RC) begin
                    mode = 2;
                    if (!m_from_settle) m_cnt = m_cnt + 8'd1;
                end
            end
        endcase
        #1;
    endtask

    task automatic test_reset();
        int rise;
        rise = -1;
        addr_in = '0; user_rst_n = 1'b1; rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        n_checks++;
        if ({sel_addr, design_rst_n, out_en, busy, switch_cnt} !== {5'd0, 1'b0, 1'b0, 1'b1, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_values: got %h want %h", {sel_addr, design_rst_n, out_en, busy, switch_cnt},
                     {5'd0, 1'b0, 1'b0, 1'b1, 8'd0});
        end
        @(negedge clk) rst = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            step();
            n_checks++;
            if ({sel_addr, design_rst_n, out_en, busy, switch_cnt} !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_seq c%0d: got %h want %h", c, {sel_addr, design_rst_n, out_en, busy, switch_cnt}, exp_vec());
            end
            if (rise < 0 && out_en === 1'b1 && design_rst_n === 1'b1) rise = c;
        end
        n_checks++;
        if (rise < 27 || rise > 29) begin
            n_fail++;
            $display("FAIL reset_release_time: got %0d want 28 (+-1)", rise);
        end
        n_checks++;
        if (switch_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_switch_cnt: got %0d want 0", switch_cnt);
        end
    endtask

    task automatic test_switch();
        int fall, selc, rise;
        fall = -1; selc = -1; rise = -1;
        addr_in = 5'd5;
        for (int c = 1; c <= 45; c++) begin
            step();
            n_checks++;
            if ({sel_addr, design_rst_n, out_en, busy, switch_cnt} !== exp_vec()) begin
                n_fail++;
                $display("FAIL switch c%0d: got %h want %h", c, {sel_addr, design_rst_n, out_en, busy, switch_cnt}, exp_vec());
            end
            if (fall < 0 && out_en === 1'b0) fall = c;
            if (selc < 0 && sel_addr === 5'd5) selc = c;
            if (fall >= 0 && rise < 0 && out_en === 1'b1) rise = c;
        end
        n_checks++;
        if (fall < 17 || fall > 20) begin n_fail++; $display("FAIL switch_fall_time: got %0d want ~19", fall); end
        n_checks++;
        if (selc - fall !== 3) begin n_fail++; $display("FAIL switch_sel_delay: got %0d want 3", selc - fall); end
        n_checks++;
        if (rise - selc !== 8) begin n_fail++; $display("FAIL switch_release_delay: got %0d want 8", rise - selc); end
        n_checks++;
        if (switch_cnt !== 8'd1) begin n_fail++; $display("FAIL switch_cnt_one: got %0d want 1", switch_cnt); end
    endtask

    task automatic test_glitch();
        bit dropped;
        dropped = 1'b0;
        addr_in = 5'd9;
        for (int c = 1; c <= 40; c++) begin
            if (c == 11) addr_in = 5'd5;
            step();
            n_checks++;
            if ({sel_addr, design_rst_n, out_en, busy, switch_cnt} !== exp_vec()) begin
                n_fail++;
                $display("FAIL glitch c%0d: got %h want %h", c, {sel_addr, design_rst_n, out_en, busy, switch_cnt}, exp_vec());
            end
            if (out_en !== 1'b1 || busy !== 1'b0) dropped = 1'b1;
        end
        n_checks++;
        if (dropped || sel_addr !== 5'd5) begin
            n_fail++;
            $display("FAIL glitch_no_switch: got dropped=%0d sel=%0d want dropped=0 sel=5", dropped, sel_addr);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] start_cnt;
        int         c;
        start_cnt = m_cnt;
        addr_in = 5'd3;
        c = 0;
        while (!(mode == 1 && k > QC + 1) && c < 100) begin
            step(); c++;
            n_checks++;
            if ({sel_addr, design_rst_n, out_en, busy, switch_cnt} !== exp_vec()) begin
                n_fail++;
                $display("FAIL b2b_first c%0d: got %h want %h", c, {sel_addr, design_rst_n, out_en, busy, switch_cnt}, exp_vec());
            end
        end
        n_checks++;
        if (c >= 100) begin n_fail++; $display("FAIL b2b_hold_timeout: got %0d cycles want <100", c); end
        addr_in = 5'd7;
        c = 0;
        while (!(mode == 2 && m_sel == 5'd7) && c < 200) begin
            step(); c++;
            n_checks++;
            if ({sel_addr, design_rst_n, out_en, busy, switch_cnt} !== exp_vec()) begin
                n_fail++;
                $display("FAIL b2b_second c%0d: got %h want %h", c, {sel_addr, design_rst_n, out_en, busy, switch_cnt}, exp_vec());
            end
        end
        n_checks++;
        if (c >= 200) begin n_fail++; $display("FAIL b2b_run_timeout: got %0d cycles want <200", c); end
        n_checks++;
        if (switch_cnt !== start_cnt + 8'd2 || sel_addr !== 5'd7) begin
            n_fail++;
            $display("FAIL b2b_count: got cnt=%0d sel=%0d want cnt=%0d sel=7", switch_cnt, sel_addr, start_cnt + 8'd2);
        end
    endtask

    task automatic test_user_rst();
        int first_low, lows;
        bit gated;
        first_low = -1; lows = 0; gated = 1'b0;
        user_rst_n = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (c == 5) user_rst_n = 1'b1;
            step();
            n_checks++;
            if ({sel_addr, design_rst_n, out_en, busy, switch_cnt} !== exp_vec()) begin
                n_fail++;
                $display("FAIL user_rst c%0d: got %h want %h", c, {sel_addr, design_rst_n, out_en, busy, switch_cnt}, exp_vec());
            end
            if (design_rst_n === 1'b0) begin
                lows++;
                if (first_low < 0) first_low = c;
            end
            if (out_en !== 1'b1 || busy !== 1'b0) gated = 1'b1;
        end
        n_checks++;
        if (first_low !== 2 || lows !== 4) begin
            n_fail++;
            $display("FAIL user_rst_pulse: got delay=%0d width=%0d want delay=2 width=4", first_low, lows);
        end
        n_checks++;
        if (gated) begin n_fail++; $display("FAIL user_rst_stays_run: got out_en/busy disturbed want out_en=1 busy=0"); end
    endtask

    task automatic test_rst_abort();
        int c;
        addr_in = 5'd12;
        c = 0;
        while (!(mode == 1 && k == 1) && c < 60) begin
            step(); c++;
            n_checks++;
            if ({sel_addr, design_rst_n, out_en, busy, switch_cnt} !== exp_vec()) begin
                n_fail++;
                $display("FAIL abort_pre c%0d: got %h want %h", c, {sel_addr, design_rst_n, out_en, busy, switch_cnt}, exp_vec());
            end
        end
        n_checks++;
        if (c >= 60) begin n_fail++; $display("FAIL abort_quiesce_timeout: got %0d cycles want <60", c); end
        #1 rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({sel_addr, design_rst_n, out_en, busy, switch_cnt} !== {5'd0, 1'b0, 1'b0, 1'b1, 8'd0}) begin
            n_fail++;
            $display("FAIL abort_async_reset: got %h want %h", {sel_addr, design_rst_n, out_en, busy, switch_cnt},
                     {5'd0, 1'b0, 1'b0, 1'b1, 8'd0});
        end
        #2 rst = 1'b0;
        c = 0;
        while (mode != 2 && c < 60) begin
            step(); c++;
            n_checks++;
            if ({sel_addr, design_rst_n, out_en, busy, switch_cnt} !== exp_vec()) begin
                n_fail++;
                $display("FAIL abort_settle c%0d: got %h want %h", c, {sel_addr, design_rst_n, out_en, busy, switch_cnt}, exp_vec());
            end
        end
        n_checks++;
        if (c >= 60 || sel_addr !== 5'd12 || switch_cnt !== 8'd0 || out_en !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_resettle: got sel=%0d cnt=%0d oe=%0d want sel=12 cnt=0 oe=1", sel_addr, switch_cnt, out_en);
        end
    endtask

    task automatic test_random();
        int            hold;
        logic [AW-1:0] prev_sel;
        logic          prev_oe;
        int            c;
        c = 0;
        while (c < 1500) begin
            addr_in = AW'($urandom_range(0, 31));
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, SC - 1) : $urandom_range(SC + 1, 60);
            for (int h = 0; h < hold; h++) begin
                user_rst_n = ($urandom_range(0, 15) != 0);
                prev_sel = sel_addr;
                prev_oe  = out_en;
                step(); c++;
                n_checks++;
                if ({sel_addr, design_rst_n, out_en, busy, switch_cnt} !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL random c%0d: got %h want %h", c, {sel_addr, design_rst_n, out_en, busy, switch_cnt}, exp_vec());
                end
                n_checks++;
                if (prev_oe === 1'b1 && sel_addr !== prev_sel) begin
                    n_fail++;
                    $display("FAIL random_sel_while_enabled c%0d: got sel %0d->%0d want unchanged", c, prev_sel, sel_addr);
                end
            end
        end
        user_rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_switch();
        test_glitch();
        test_back_to_back();
        test_user_rst();
        test_rst_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_sel_ctrl.md
# mux_sel_ctrl

Sequencing controller for the shared design multiplexer: it takes the raw design-select address from the input pads, synchronizes and debounces it, and performs a safe switchover between designs. During a switchover it gates the multiplexed outputs off, changes the select, and holds the newly selected design in reset before releasing it. It sits between the pad ring and `basic_mux`. It drives the mux `addr` input, the reset bit fed into the selected design, and an output-enable gate applied to `uo_out`/`uio_oe`.

## Interface
Parameters:
- `ADDR_W`, 5, select address width
- `SYNC_STAGES`, 2, flops in each synchronizer chain (≥2)
- `STABLE_CYCLES`, 16, consecutive cycles a new synced address must hold before acceptance (≥1)
- `QUIESCE_CYCLES`, 2, cycles outputs are gated before select changes (≥1)
- `RST_CYCLES`, 8, cycles the new design is held in reset (≥1)

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  asynchronous, active-high reset
- `addr_in`  in  ADDR_W  raw select from pads (asynchronous)
- `user_rst_n`  in  1  raw design reset from pad (asynchronous, active-low)
- `sel_addr`  out  ADDR_W  committed select to `basic_mux.addr`
- `design_rst_n`  out  1  reset bit routed into `iw[1]`
- `out_en`  out  1  AND-gate for `uo_out`; forces `uio_oe` to 0 when low
- `busy`  out  1  high in any state other than RUN
- `switch_cnt`  out  8  completed switchovers, wraps 255→0

## Operation
- `addr_in` and `user_rst_n` each pass through `SYNC_STAGES` flops. The results are `addr_s` and `urst_s`.
- Stability counter: it clears when `addr_s` differs from its previous-cycle value and otherwise saturates at `STABLE_CYCLES`. `stable` is high when the count equals `STABLE_CYCLES`.
- FSM states are SETTLE, QUIESCE, SWITCH, HOLD_RST and RUN.
  - SETTLE: entered on reset. Waits for `stable`, latches `target=addr_s`, then goes to SWITCH. Quiescing is skipped because outputs are already off.
  - RUN: when `stable` is high and `addr_s != sel_addr`, latch `target=addr_s` and go to QUIESCE.
  - QUIESCE: `out_en=0`, `design_rst_n=0`. Stays `QUIESCE_CYCLES` cycles, then goes to SWITCH.
  - SWITCH: one cycle. `sel_addr<=target`, then goes to HOLD_RST.
  - HOLD_RST: `design_rst_n=0`, `out_en=0`. Stays `RST_CYCLES` cycles, then goes to RUN and `switch_cnt` increments. The increment is skipped when coming from SETTLE.
- Outputs in RUN: `out_en=1` and `design_rst_n=urst_s`. In all other states both are 0.
- Boundary rules:
  - Address changes during QUIESCE, SWITCH or HOLD_RST do not alter `target`. They are re-evaluated in RUN once `stable`.
  - A glitch shorter than `STABLE_CYCLES` never causes a switch.
  - If `addr_s` returns to `sel_addr` before `stable`, nothing happens.
  - `urst_s` low in RUN does not leave RUN.
  - Asserting `rst` at any point aborts the operation immediately and asynchronously.

## Timing
- Reset values: `sel_addr=0`, `design_rst_n=0`, `out_en=0`, `busy=1`, `switch_cnt=0`, state SETTLE, synchronizers and counters 0.
- Pad change to `addr_s`: `SYNC_STAGES` cycles. To `stable`: `STABLE_CYCLES` more cycles.
- RUN→QUIESCE is registered. `out_en` falls on the edge after `stable` is seen.
- `sel_addr` changes exactly `QUIESCE_CYCLES+1` cycles after `out_en` falls.
- `out_en` and `design_rst_n` rise together, `RST_CYCLES` cycles after `sel_addr` changes.
- Invariant: `sel_addr` never changes while `out_en=1`.

## Structure
- Package `mux_ctrl_pkg`:
  - state enum `mux_ctrl_state_t`
  - default parameter constants
  - `SW_CNT_W=8`
- Sub-module `sync_stable`: parameterized-width synchronizer plus stability counter with a `stable` output. It is instantiated once for `addr_in`. `user_rst_n` uses a 1-bit synchronizer only.

## Test plan
Defaults are used unless stated.
- Reset, then `addr_in=0` held. Required: `sel_addr=0`; `out_en`/`design_rst_n` rise together 2+16+1+1+8 cycles (±1) after `rst` falls; `switch_cnt=0`.
- In RUN, `addr_in` 0→5 held. Required:
  - `out_en` falls about 19 cycles after the change.
  - `sel_addr=5` exactly 3 cycles later.
  - Release 8 cycles after that.
  - `switch_cnt=1`.
- In RUN, `addr_in` 5→9 for 10 cycles, then back to 5. Required: no state change, `out_en` stays 1, `sel_addr=5`.
- Switch to 3, then during HOLD_RST set `addr_in=7` and hold. Required:
  - The switch to 3 completes.
  - A second full sequence follows to 7.
  - `switch_cnt` increments by 2.
- In RUN, pulse `user_rst_n` low 4 cycles. Required:
  - `design_rst_n` goes low 4 cycles, delayed by 2.
  - `out_en` stays 1.
  - `busy` stays 0.
- Assert `rst` during QUIESCE. Required: all outputs take reset values immediately, and the bench then completes the SETTLE sequence to the held `addr_in`.
